reg_set_clear: RTL and testbench
================================

// Module: reg_set_clear
//
// PURPOSE
// - Generic set/clear flag register: a bit goes high on a set pulse and stays high until a clear pulse.
// - Used by packet-filter blocks to track sticky per-frame conditions.
//   Example: "current frame dropped" is set by drop_current and cleared by the ingress tlast beat.
// - Pure storage primitive. Its output feeds FSM logic and assertions. No handshake of its own.
//
// PARAMETERS
// - WIDTH        default 1     number of independent flag bits; set/clear/q are per-bit vectors
// - RESET_VALUE  default '0    value loaded into q while reset is asserted (WIDTH bits)
// - SET_PRIORITY default 0     0: clear wins when set and clear coincide; 1: set wins
//
// PORTS
// - clk    input   1      single clock; all state updates on its rising edge
// - reset  input   1      asynchronous, active-low reset (asserted when 0)
// - set    input   WIDTH  per-bit set request, sampled on rising clk
// - clear  input   WIDTH  per-bit clear request, sampled on rising clk
// - q      output  WIDTH  registered flag value
//
// BEHAVIOUR
// - Reset
//   - reset==0 forces q=RESET_VALUE immediately, without waiting for clk.
//   - q holds RESET_VALUE while reset is low.
//   - On reset deassertion, the first update happens at the next rising clk.
//   - Any set/clear sampled while reset is low is ignored.
// - Per bit i, at each rising clk with reset==1:
//   - set=1,clear=0 -> q[i]<=1
//   - set=0,clear=1 -> q[i]<=0
//   - set=0,clear=0 -> q[i] holds
//   - set=1,clear=1 -> q[i]<=SET_PRIORITY ? 1 : 0
// - Latency: exactly one clock from a sampled set/clear to the visible q change.
//   No combinational path from set/clear to q.
// - Bits are fully independent. No cross-bit interaction for any WIDTH.
// - Redundant requests are no-ops with no side effects:
//   - set while already set: q stays 1.
//   - clear while already clear: q stays 0.
// - Reset mid-operation (e.g. mid-frame) discards the stored flag. Nothing is remembered across reset.
// - X/Z on set/clear is not qualified. Callers drive clean 0/1 outside reset.
//   Under ASSERT, flag X on set/clear when reset==1.
//
// STRUCTURE
// - Single always_ff with async active-low reset; next-state per bit computed in a small always_comb.
// - Shared header (packet_filter.svh / filter_defs.svh) holds no new typedefs.
//   SET_PRIORITY encodings are defined there as `REG_SC_CLEAR_WINS=0 and `REG_SC_SET_WINS=1.
// - No sub-module: the block is a leaf primitive.
// - Optional `ifdef ASSERT block holds these properties:
//   - q follows the truth table one cycle later.
//   - q==RESET_VALUE during reset.
//
// TESTING
// - Reset: hold reset=0 with set=1 -> q=RESET_VALUE asynchronously, with no clk edge required.
//   Release -> q unchanged until the first edge.
// - Set/hold/clear (WIDTH=1): set pulse at cycle 2 -> q=1 from cycle 3.
//   Idle cycles 3..6 -> q stays 1. Clear pulse at cycle 7 -> q=0 from cycle 8.
// - Coincident set and clear:
//   - SET_PRIORITY=0, q=1 -> q=0 next cycle.
//   - SET_PRIORITY=1, q=0 -> q=1 next cycle.
// - Frame-drop use case: drop_current (set) mid-frame -> q=1 until the tlast beat.
//   tlast clear -> q=0 on the following cycle. Back-to-back frames both tracked correctly.
// - Multi-bit: WIDTH=4, set=4'b0101, then clear=4'b0100.
//   q=4'b0101, then q=4'b0001. Untouched bits remain stable.
// - Async reset mid-operation: q=4'b1111, drop reset between edges -> q=RESET_VALUE within the same cycle.

Source files
------------

// File: rtl/reg_set_clear_pkg.sv
// Shared encodings and per-bit next-state rule for the sticky set/clear flag register.
package reg_set_clear_pkg;

    localparam bit SC_CLEAR_WINS = 1'b0;
    localparam bit SC_SET_WINS   = 1'b1;

    // Next value of one flag bit given its current value and the sampled requests.
    function automatic logic sc_next_bit(
        input logic cur,
        input logic set_req,
        input logic clear_req,
        input logic set_wins
    );
        if (set_req && clear_req) return set_wins;
        if (set_req)              return 1'b1;
        if (clear_req)            return 1'b0;
        return cur;
    endfunction

endpackage : reg_set_clear_pkg

// File: rtl/reg_set_clear.sv
// Per-bit sticky flag register: set pulse raises a bit, clear pulse drops it,
// coincident requests resolved by SET_PRIORITY; async active-low reset.
module reg_set_clear
    import reg_set_clear_pkg::*;
#(
    parameter int unsigned      WIDTH        = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter bit               SET_PRIORITY = SC_CLEAR_WINS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] clear,
    output logic [WIDTH-1:0] q
);

    localparam logic SET_WINS = (SET_PRIORITY == SC_SET_WINS);

    logic [WIDTH-1:0] q_next;

    // Bits are independent; each follows the same set/clear rule.
    always_comb begin
        q_next = q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            q_next[i] = sc_next_bit(q[i], set[i], clear[i], SET_WINS);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_VALUE;
        end else begin
            q <= q_next;
        end
    end

`ifdef ASSERT
    a_clean_inputs: assert property (@(posedge clk) disable iff (!reset)
        !$isunknown({set, clear}));

    a_truth_table: assert property (@(posedge clk) disable iff (!reset)
        $past(reset) |-> (q == $past(q_next)));

    a_reset_value: assert property (@(posedge clk)
        !reset |-> (q == RESET_VALUE));
`endif

endmodule : reg_set_clear

// File: tb/tb_reg_set_clear.sv
// Directed bench for reg_set_clear: clear-wins and set-wins 4-bit instances plus a 1-bit frame-drop flag.
module tb_reg_set_clear;
    import reg_set_clear_pkg::*;

    logic       clk   = 1'b0;
    logic       run   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] set   = '0;
    logic [3:0] clear = '0;
    logic [3:0] q_cw;
    logic [3:0] q_sw;
    logic       set1   = 1'b0;
    logic       clear1 = 1'b0;
    logic       q1;

    int checks = 0;
    int errors = 0;

    reg_set_clear #(.WIDTH(4), .RESET_VALUE(4'b0000), .SET_PRIORITY(SC_CLEAR_WINS)) u_cw (
        .clk(clk), .reset(reset), .set(set), .clear(clear), .q(q_cw)
    );

    reg_set_clear #(.WIDTH(4), .RESET_VALUE(4'b1010), .SET_PRIORITY(SC_SET_WINS)) u_sw (
        .clk(clk), .reset(reset), .set(set), .clear(clear), .q(q_sw)
    );

    reg_set_clear #(.WIDTH(1), .RESET_VALUE(1'b0), .SET_PRIORITY(SC_CLEAR_WINS)) u_w1 (
        .clk(clk), .reset(reset), .set(set1), .clear(clear1), .q(q1)
    );

    // Clock can be held still to show reset acts without any edge.
    initial begin
        forever begin
            #5;
            if (run) clk = ~clk;
        end
    end

    typedef struct {
        logic [3:0] set;
        logic [3:0] clear;
        logic [3:0] exp_cw;
        logic [3:0] exp_sw;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive requests just after an edge, then observe just after the next edge.
    task automatic cycle4(input logic [3:0] s, input logic [3:0] c);
        set   = s;
        clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle1(input logic s, input logic c);
        set1   = s;
        clear1 = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{4'b0101, 4'b0000, 4'b0101, 4'b0101};
        vecs[1]  = '{4'b0000, 4'b0100, 4'b0001, 4'b0001};
        vecs[2]  = '{4'b0000, 4'b0000, 4'b0001, 4'b0001};
        vecs[3]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0001};
        vecs[4]  = '{4'b0110, 4'b0110, 4'b0000, 4'b0111};
        vecs[5]  = '{4'b1111, 4'b0000, 4'b1111, 4'b1111};
        vecs[6]  = '{4'b1111, 4'b0000, 4'b1111, 4'b1111};
        vecs[7]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};
        vecs[8]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};
        vecs[9]  = '{4'b1000, 4'b0001, 4'b1000, 4'b1000};
        vecs[10] = '{4'b0011, 4'b1100, 4'b0011, 4'b0011};
        vecs[11] = '{4'b1100, 4'b1100, 4'b0011, 4'b1111};

        // Asynchronous reset with the clock stopped and set requests active.
        #1;
        set   = 4'b1111;
        set1  = 1'b1;
        reset = 1'b0;
        #2;
        check("async_reset_cw", q_cw, 4'b0000);
        check("async_reset_sw", q_sw, 4'b1010);
        check("async_reset_w1", 4'(q1), 4'b0000);

        run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold_cw", q_cw, 4'b0000);
        check("reset_hold_sw", q_sw, 4'b1010);
        check("reset_hold_w1", 4'(q1), 4'b0000);

        reset = 1'b1;
        #2;
        check("release_no_edge_cw", q_cw, 4'b0000);
        check("release_no_edge_sw", q_sw, 4'b1010);
        @(posedge clk);
        #1;
        check("first_edge_cw", q_cw, 4'b1111);
        check("first_edge_sw", q_sw, 4'b1111);
        check("first_edge_w1", 4'(q1), 4'b0001);

        set1 = 1'b0;
        cycle4(4'b0000, 4'b1111);
        check("clear_all_cw", q_cw, 4'b0000);
        check("clear_all_sw", q_sw, 4'b0000);
        cycle1(1'b0, 1'b1);
        check("w1_cleared", 4'(q1), 4'b0000);
        clear1 = 1'b0;

        for (int i = 0; i < 12; i++) begin
            set   = vecs[i].set;
            clear = vecs[i].clear;
            #1;
            check($sformatf("vec%0d_cw_pre_edge", i), q_cw, (i == 0) ? 4'b0000 : vecs[i-1].exp_cw);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_cw", i), q_cw, vecs[i].exp_cw);
            check($sformatf("vec%0d_sw", i), q_sw, vecs[i].exp_sw);
        end

        // 1-bit set / hold / clear with one-cycle latency.
        set1 = 1'b1;
        #1;
        check("w1_set_not_comb", 4'(q1), 4'b0000);
        @(posedge clk);
        #1;
        check("w1_set", 4'(q1), 4'b0001);
        for (int i = 0; i < 4; i++) begin
            cycle1(1'b0, 1'b0);
            check($sformatf("w1_idle%0d", i), 4'(q1), 4'b0001);
        end
        cycle1(1'b0, 1'b1);
        check("w1_clear", 4'(q1), 4'b0000);

        // Back-to-back 5-beat frames: drop on beat 2, none, drop on beat 1; tlast clears.
        for (int f = 0; f < 3; f++) begin
            automatic int drop_beat = (f == 0) ? 2 : ((f == 2) ? 1 : -1);
            automatic logic dropped = 1'b0;
            for (int b = 1; b <= 5; b++) begin
                cycle1(b == drop_beat, b == 5);
                if (b == drop_beat) dropped = 1'b1;
                if (b == 5) dropped = 1'b0;
                check($sformatf("frame%0d_beat%0d", f, b), 4'(q1), 4'(dropped));
            end
        end
        cycle1(1'b0, 1'b0);

        // Asynchronous reset between edges while all flags are set.
        cycle4(4'b1111, 4'b0000);
        check("mid_full_cw", q_cw, 4'b1111);
        check("mid_full_sw", q_sw, 4'b1111);
        #3;
        reset = 1'b0;
        #1;
        check("mid_reset_cw", q_cw, 4'b0000);
        check("mid_reset_sw", q_sw, 4'b1010);
        @(posedge clk);
        #1;
        check("mid_reset_held_sw", q_sw, 4'b1010);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_set_cw", q_cw, 4'b1111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_reg_set_clear
